// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream style byte channel: data, vld, rdy; a transfer happens on vld & rdy.
interface axis_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         vld;
  logic         rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Empty FIFO presents zero so the stream data is defined out of reset.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a byte
// stream through a small FIFO; bad frames raise frame_err, dropped bytes raise overrun.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   rx,
  output logic   frame_err,
  output logic   overrun,
  axis_if.master axis_o
);
  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(UART_DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV - DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_W - 1);

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   rx_meta_q, rx_s_q, rx_prev_q;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   tick, push, pop;
  logic                   fifo_empty, fifo_full;
  logic [UART_DATA_W-1:0] fifo_dout;
`ifdef UART_RX_PARITY_EN
  logic                   par_err_q, par_err_d;
`endif

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Falling edge, not level: a held-low line (break) cannot retrigger.
        if (!rx_s_q && rx_prev_q) begin
          state_d = START;
          cnt_d   = CNT_START;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      START: if (tick) begin
        state_d = rx_s_q ? IDLE : DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        shift_d = {rx_s_q, shift_q[UART_DATA_W-1:1]};
        bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == BIT_LAST) state_d = PARITY;
`else
        if (bit_q == BIT_LAST) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_err_d = par_err_q | (^{shift_q, rx_s_q});
        state_d   = STOP;
      end
      STOP: if (tick) begin
        state_d     = IDLE;
        push        = rx_s_q && !par_err_q;
        frame_err_d = !(rx_s_q && !par_err_q);
      end
`else
      STOP: if (tick) begin
        state_d     = IDLE;
        push        = rx_s_q;
        frame_err_d = !rx_s_q;
      end
`endif
      default: state_d = IDLE;
    endcase
    overrun_d = push && fifo_full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign pop = !fifo_empty && axis_o.rdy;

  sync_fifo #(
    .WIDTH(UART_DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (shift_q),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign axis_o.vld  = !fifo_empty;
  assign axis_o.data = fifo_dout;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed + randomized bench for uart_rx_axis with a queue-based reference model.
module tb_uart_rx_axis;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 4;
  localparam int PER      = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic frame_err;
  logic overrun;

  axis_if #(.W(8)) axis ();

  uart_rx_axis #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .frame_err(frame_err),
    .overrun  (overrun),
    .axis_o   (axis)
  );

  always #(PER/2) clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_q[$];
  time        got_t_q[$];
  logic [7:0] exp_q[$];
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, hold_viol = 0;
  int exp_fe = 0, exp_ov = 0;
  time last_start_t = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = '0;

  // Observes the stream and flag pulses at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (axis.vld && axis.rdy) begin
      got_q.push_back(axis.data);
      got_t_q.push_back($time);
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
    if (hold_prev && axis.vld && axis.data !== data_prev) hold_viol++;
    hold_prev = axis.vld && !axis.rdy;
    data_prev = axis.data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 axis.rdy = v;
    @(negedge clk);
  endtask

  // Drives one frame starting at the current falling clock edge; the model is updated
  // from the frame rules only (good stop and parity => byte expected, else frame error).
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_good);
    logic [7:0] d;
    d = b;
    rx = 1'b0;
    last_start_t = $time;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(DIV);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_good ? (^d) : ~(^d);
    idle(DIV);
`endif
    rx = stop_bit;
    idle(DIV);
    rx = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (stop_bit && par_good) exp_q.push_back(b);
    else exp_fe++;
`else
    if (stop_bit) exp_q.push_back(b);
    else exp_fe++;
`endif
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    got_t_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #(PER * 60000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] b;
    axis.rdy = 1'b1;
    idle(3);
    chk("rst_vld", axis.vld, 1'b0);
    chk("rst_data", axis.data, 8'h00);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    idle(5);

    send_frame(8'h42, 1'b1, 1'b1);
    idle(5);
    lat = (got_t_q.size() > 0) ? int'((got_t_q[0] - last_start_t) / PER) : -1;
    chk("single_latency_window", (lat >= NB*DIV + DIV/2 + 1) && (lat <= NB*DIV + DIV/2 + 4), 1'b1);
    check_stream("single");
    chk("single_frame_err", fe_cnt, exp_fe);

    send_frame(8'h42, 1'b1, 1'b1);
    send_frame(8'h45, 1'b1, 1'b1);
    send_frame(8'h47, 1'b1, 1'b1);
    send_frame(8'h4E, 1'b1, 1'b1);
    idle(5);
    check_stream("b2b_begn");

    for (int k = 0; k < 6; k++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    idle(5);
    check_stream("b2b_random");

    set_rdy(1'b0);
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b1);
    idle(5);
    void'(exp_q.pop_back());
    exp_ov++;
    chk("full_vld_held", axis.vld, 1'b1);
    chk("full_data_head", axis.data, 8'h01);
    chk("full_overrun", ov_cnt, exp_ov);
    set_rdy(1'b1);
    idle(8);
    check_stream("drain");

    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    check_stream("glitch");
    chk("glitch_frame_err", fe_cnt, exp_fe);

    send_frame(8'hA5, 1'b0, 1'b1);
    idle(3);
    chk("bad_stop_frame_err", fe_cnt, exp_fe);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(5);
    check_stream("after_bad_stop");

    rx = 1'b0;
    exp_fe++;
    idle(20 * DIV);
    chk("break_frame_err", fe_cnt, exp_fe);
    rx = 1'b1;
    idle(2 * DIV);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(5);
    check_stream("after_break");

    for (int k = 0; k < 8; k++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0));
      idle(3);
    end
    idle(3);
    check_stream("random_errs");
    chk("random_frame_err", fe_cnt, exp_fe);

    set_rdy(1'b0);
    send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    idle(3);
    chk("pre_rst_vld", axis.vld, 1'b1);
    rx = 1'b0;
    idle(4 * DIV);
    #2 rst = 1'b1;
    #1 chk("rst_async_vld", axis.vld, 1'b0);
    exp_q.delete();
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    set_rdy(1'b1);
    idle(3);
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 1'b1);
    idle(5);
    check_stream("post_rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(5);
    chk("parity_bad_frame_err", fe_cnt, exp_fe);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(5);
    check_stream("parity");
`endif

    chk("final_frame_err", fe_cnt, exp_fe);
    chk("final_overrun", ov_cnt, exp_ov);
    chk("flags_same_cycle", both_cnt, 0);
    chk("hold_stability", hold_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
